mem_fifo_ctrl: RTL

MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

---
 rtl/mem_fifo_ctrl_if.sv | 22 ++
 rtl/mem_fifo_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/mem_fifo_ctrl_if.sv
// Streaming handshake bundle for mem_fifo_ctrl: upstream push side and
// downstream pop side.
interface mem_fifo_ctrl_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mem_fifo_ctrl.sv
// FIFO controller over an external single-port memory: one write or one read
// per cycle, with fair arbitration on conflicts and a registered output word.
module mem_fifo_ctrl #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_fifo_ctrl_if.slave        bus,
  input  logic                  flush,
  output logic [AW-1:0]         mem_addr,
  output logic                  mem_we,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  // Which side wins the next write/read conflict.
  typedef enum logic {
    PRI_WR = 1'b0,
    PRI_RD = 1'b1
  } pri_e;

  pri_e          pri_q, pri_d;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_q;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          wr_req, rd_req, wr_gnt, rd_gnt;

  assign count         = count_q;
  assign full          = (count_q == DEPTH);
  assign empty         = (count_q == '0);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.in_ready  = wr_gnt;

  // rst_n gates the write request so in_ready stays low while in reset.
  always_comb begin
    wr_req = rst_n && bus.in_valid && !full && !flush;
    rd_req = rst_n && !empty && (!out_valid_q || bus.out_ready) && !flush;
    wr_gnt = wr_req && (!rd_req || (pri_q == PRI_WR));
    rd_gnt = rd_req && (!wr_req || (pri_q == PRI_RD));

    pri_d = pri_q;
    if (flush) begin
      pri_d = PRI_WR;
    end else if (wr_req && rd_req) begin
      pri_d = (pri_q == PRI_WR) ? PRI_RD : PRI_WR;
    end

    mem_we    = wr_gnt;
    mem_addr  = wr_gnt ? wptr : rptr;
    mem_wdata = bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_WR;
    end else begin
      pri_q <= pri_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_gnt) begin
        wptr    <= wptr + AW'(1);
        count_q <= count_q + (AW+1)'(1);
      end
      if (rd_gnt) begin
        out_data_q  <= mem_rdata;
        out_valid_q <= 1'b1;
        rptr        <= rptr + AW'(1);
        count_q     <= count_q - (AW+1)'(1);
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
